mdu_unit: RTL and testbench

- Multi-cycle multiply/divide unit in the E stage of the pipelined MIPS core, alongside the combinational ALU.
- Takes the same rs/rt operands, runs mult/multu/div/divu over several cycles, and owns the HI/LO registers.
- Busy drives the hazard unit, so dependent MDU instructions stall in D.

---
 rtl/mdu_pkg.sv | 46 ++++
 rtl/mdu_calc.sv | 64 ++++++
 rtl/mdu_unit.sv | 83 ++++++++
 tb/tb_mdu_unit.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared MDU operation encodings, default latencies and helpers.
// Optional macro MDU_MADD_EN enables the madd/maddu/msub/msubu launch ops.
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'h0,
        OP_MULT  = 4'h1,
        OP_MULTU = 4'h2,
        OP_DIV   = 4'h3,
        OP_DIVU  = 4'h4,
        OP_MTHI  = 4'h5,
        OP_MTLO  = 4'h6,
        OP_MADD  = 4'h7,
        OP_MADDU = 4'h8,
        OP_MSUB  = 4'h9,
        OP_MSUBU = 4'hA
    } mdu_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // 64-bit {HI,LO} result type
    typedef logic [63:0] mdu_res_t;

    function automatic mdu_res_t pack_hilo(input logic [31:0] hi,
                                           input logic [31:0] lo);
        return {hi, lo};
    endfunction

    // Ops that occupy the unit for several cycles when Start is set
    function automatic logic is_launch(input logic [3:0] op);
        logic l;
        l = (op == OP_MULT) || (op == OP_MULTU) ||
            (op == OP_DIV)  || (op == OP_DIVU);
`ifdef MDU_MADD_EN
        l = l || (op == OP_MADD) || (op == OP_MADDU) ||
                 (op == OP_MSUB) || (op == OP_MSUBU);
`endif
        return l;
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: combinational {HI,LO} result for a latched MDU op.
// Ports: i_a/i_b latched operands, i_op latched op, i_hi/i_lo accumulator;
//        o_res 64-bit {HI,LO}, o_we write enable (low on divide by zero).
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [3:0]  i_op,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    output mdu_res_t    o_res,
    output logic        o_we
);

    logic [63:0] w_sprod;
    logic [63:0] w_uprod;
    logic [63:0] w_acc;
    logic        w_bz;
    logic [31:0] w_ma;
    logic [31:0] w_mb;
    logic [31:0] w_ub;
    logic [31:0] w_sqm;
    logic [31:0] w_srm;
    logic [31:0] w_sq;
    logic [31:0] w_sr;
    logic [31:0] w_uq;
    logic [31:0] w_ur;

    assign w_sprod = $signed({{32{i_a[31]}}, i_a}) *
                     $signed({{32{i_b[31]}}, i_b});
    assign w_uprod = {32'b0, i_a} * {32'b0, i_b};
    assign w_acc   = pack_hilo(i_hi, i_lo);

    // Signed divide done on magnitudes; 0x80000000/-1 falls out as
    // quotient 0x80000000, remainder 0 without special casing.
    assign w_bz  = (i_b == 32'd0);
    assign w_ma  = i_a[31] ? (32'd0 - i_a) : i_a;
    assign w_mb  = w_bz ? 32'd1 : (i_b[31] ? (32'd0 - i_b) : i_b);
    assign w_ub  = w_bz ? 32'd1 : i_b;
    assign w_sqm = w_ma / w_mb;
    assign w_srm = w_ma % w_mb;
    assign w_sq  = (i_a[31] ^ i_b[31]) ? (32'd0 - w_sqm) : w_sqm;
    assign w_sr  = i_a[31] ? (32'd0 - w_srm) : w_srm;
    assign w_uq  = i_a / w_ub;
    assign w_ur  = i_a % w_ub;

    always_comb begin
        o_res = w_acc;
        o_we  = 1'b0;
        case (i_op)
            OP_MULT:  begin o_res = w_sprod;           o_we = 1'b1;  end
            OP_MULTU: begin o_res = w_uprod;           o_we = 1'b1;  end
            OP_DIV:   begin o_res = {w_sr, w_sq};      o_we = !w_bz; end
            OP_DIVU:  begin o_res = {w_ur, w_uq};      o_we = !w_bz; end
            OP_MADD:  begin o_res = w_acc + w_sprod;   o_we = 1'b1;  end
            OP_MADDU: begin o_res = w_acc + w_uprod;   o_we = 1'b1;  end
            OP_MSUB:  begin o_res = w_acc - w_sprod;   o_we = 1'b1;  end
            OP_MSUBU: begin o_res = w_acc - w_uprod;   o_we = 1'b1;  end
            default:  begin o_res = w_acc;             o_we = 1'b0;  end
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle mult/div unit owning HI/LO (optional MDU_MADD_EN).
// Ports: clk, reset (sync, active-high), A/B operands, MDUOp, Start;
//        Busy (op in flight), HI/LO registers.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUOp,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES
                                                       : DIV_CYCLES;
    localparam int CNT_W = $clog2(MAXC + 1);

    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [3:0]       r_op;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;

    mdu_res_t w_res;
    logic     w_we;

    mdu_calc u_calc (
        .i_a   (r_a),
        .i_b   (r_b),
        .i_op  (r_op),
        .i_hi  (r_hi),
        .i_lo  (r_lo),
        .o_res (w_res),
        .o_we  (w_we)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_op   <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (r_busy) begin
            // Everything else, including mthi/mtlo, is ignored while busy
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                r_busy <= 1'b0;
                if (w_we) begin
                    r_hi <= w_res[63:32];
                    r_lo <= w_res[31:0];
                end
            end
        end else if (Start && is_launch(MDUOp)) begin
            r_a    <= A;
            r_b    <= B;
            r_op   <= MDUOp;
            r_busy <= 1'b1;
            r_cnt  <= is_div(MDUOp) ? CNT_W'(DIV_CYCLES)
                                    : CNT_W'(MULT_CYCLES);
        end else if (MDUOp == OP_MTHI) begin
            r_hi <= A;
        end else if (MDUOp == OP_MTLO) begin
            r_lo <= A;
        end
    end

    assign Busy = r_busy;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed scoreboard bench for mdu_unit.
// Expected {HI,LO} pushed at launch, popped when Busy drops.
module tb_mdu_unit;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  MDUOp;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] sb_q[$];

    mdu_unit dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .MDUOp (MDUOp),
        .Start (Start),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int n,
                          input bit intrude);
        int cnt;
        logic [63:0] e;
        sb_q.push_back(exp);
        A = a; B = b; MDUOp = op; Start = 1'b1;
        tick();
        Start = 1'b0; MDUOp = OP_NONE;
        A = $urandom; B = $urandom;
        chk({tag, "_busy_start"}, {31'd0, Busy}, 32'd1);
        cnt = 1;
        while (Busy === 1'b1 && cnt < 200) begin
            if (intrude && cnt == 1) begin
                MDUOp = OP_MTLO; A = 32'hAA;
            end else if (intrude && cnt == 2) begin
                MDUOp = OP_DIV; Start = 1'b1; A = 32'd100; B = 32'd7;
            end else begin
                MDUOp = OP_NONE; Start = 1'b0;
            end
            tick();
            if (Busy === 1'b1) cnt++;
        end
        MDUOp = OP_NONE; Start = 1'b0;
        e = sb_q.pop_front();
        chk({tag, "_busy_len"}, cnt, n);
        chk({tag, "_hi"}, HI, e[63:32]);
        chk({tag, "_lo"}, LO, e[31:0]);
    endtask

    initial begin
        reset = 1'b1; A = '0; B = '0; MDUOp = OP_NONE; Start = 1'b0;
        tick(); tick();
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        reset = 1'b0;
        tick();

        run_op("mult_neg", OP_MULT, 32'hFFFFFFFE, 32'd3,
               64'hFFFFFFFF_FFFFFFFA, 5, 1'b0);
        run_op("multu", OP_MULTU, 32'hFFFFFFFE, 32'd3,
               64'h00000002_FFFFFFFA, 5, 1'b0);
        run_op("mult_big", OP_MULT, 32'h7FFFFFFF, 32'h80000000,
               64'hC0000000_80000000, 5, 1'b0);
        run_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2,
               64'hFFFFFFFF_FFFFFFFD, 10, 1'b0);
        run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF,
               64'h00000000_80000000, 10, 1'b0);
        run_op("divu_big", OP_DIVU, 32'hFFFFFFFF, 32'h10,
               64'h0000000F_0FFFFFFF, 10, 1'b0);
        run_op("divu", OP_DIVU, 32'd100, 32'd7,
               64'h00000002_0000000E, 10, 1'b0);

        MDUOp = OP_MTHI; A = 32'h1234; Start = 1'b0;
        tick();
        MDUOp = OP_NONE;
        chk("mthi_hi", HI, 32'h1234);
        chk("mthi_lo", LO, 32'h0000000E);

        run_op("div0", OP_DIVU, 32'd5, 32'd0,
               64'h00001234_0000000E, 10, 1'b0);

        run_op("guard", OP_MULT, 32'd6, 32'd7,
               64'h00000000_0000002A, 5, 1'b1);
        tick();
        chk("guard_idle", {31'd0, Busy}, 32'd0);

        MDUOp = OP_MTHI; A = 32'd0; tick();
        MDUOp = OP_MTLO; A = 32'hFFFFFFFF; tick();
        MDUOp = OP_NONE;
`ifdef MDU_MADD_EN
        run_op("maddu", OP_MADDU, 32'd1, 32'd1,
               64'h00000001_00000000, 5, 1'b0);
`else
        A = 32'd1; B = 32'd1; MDUOp = OP_MADDU; Start = 1'b1;
        tick();
        Start = 1'b0; MDUOp = OP_NONE;
        chk("maddu_off_busy", {31'd0, Busy}, 32'd0);
        repeat (6) tick();
        chk("maddu_off_hi", HI, 32'd0);
        chk("maddu_off_lo", LO, 32'hFFFFFFFF);
`endif

        A = 32'd100; B = 32'd7; MDUOp = OP_DIV; Start = 1'b1;
        tick();
        Start = 1'b0; MDUOp = OP_NONE;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_busy", {31'd0, Busy}, 32'd0);
        chk("midrst_hi", HI, 32'd0);
        chk("midrst_lo", LO, 32'd0);
        repeat (12) tick();
        chk("midrst_late_busy", {31'd0, Busy}, 32'd0);
        chk("midrst_late_hi", HI, 32'd0);
        chk("midrst_late_lo", LO, 32'd0);
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
